// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit for the 36-bit core.
// Optional macro CTRL_ILLEGAL_TRAP_EN: an illegal opcode halts the core instead of executing as NOP.
module ctrl_sequencer #(
  parameter int DATA_WIDTH     = 36,
  parameter int IMM_MAX_WIDTH  = 14,
  parameter int SELECT_WIDTH   = 2,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [DATA_WIDTH-1:0]     i_instr,
  input  logic                      i_imem_ack,
  output logic                      o_imem_req,
  input  logic                      i_dmem_ack,
  output logic                      o_dmem_req,
  output logic                      o_dmem_we,
  input  logic                      i_alu_zero,
  output logic [IMM_MAX_WIDTH-1:0]  o_imm_raw,
  output logic [SELECT_WIDTH-1:0]   o_imm_sel,
  output logic [2:0]                o_alu_op,
  output logic                      o_alu_src_imm,
  output logic [REG_ADDR_WIDTH-1:0] o_rd,
  output logic [REG_ADDR_WIDTH-1:0] o_rs1,
  output logic [REG_ADDR_WIDTH-1:0] o_rs2,
  output logic                      o_reg_we,
  output logic                      o_wb_sel,
  output logic                      o_pc_we,
  output logic [1:0]                o_pc_sel,
  output logic                      o_halted,
  output logic                      o_illegal
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [SELECT_WIDTH-1:0] SEL_NONE = '0;
  localparam logic [SELECT_WIDTH-1:0] SEL_I    = SELECT_WIDTH'(1);
  localparam logic [SELECT_WIDTH-1:0] SEL_J    = SELECT_WIDTH'(2);

  localparam int RD_HI  = DATA_WIDTH - 5;
  localparam int RS1_HI = RD_HI - REG_ADDR_WIDTH;
  localparam int RS2_HI = RS1_HI - REG_ADDR_WIDTH;
  localparam int GAP_HI = RS2_HI - REG_ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic                      r_run;
  logic [DATA_WIDTH-1:0]     r_ir;
  logic                      r_taken;
  logic [IMM_MAX_WIDTH-1:0]  r_imm_raw;
  logic [SELECT_WIDTH-1:0]   r_imm_sel;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic [REG_ADDR_WIDTH-1:0] r_rs1;
  logic [REG_ADDR_WIDTH-1:0] r_rs2;

  logic [3:0] w_opcode;
  logic       w_is_legal;
  logic       w_is_itype;
  logic       w_is_jtype;
  logic       w_is_mem;
  logic       w_writes_reg;
  logic [2:0] w_alu_op;
  logic       w_alu_src_imm;
  logic       w_unused_ir;

  assign w_opcode    = r_ir[DATA_WIDTH-1 -: 4];
  assign w_unused_ir = ^r_ir[GAP_HI:IMM_MAX_WIDTH];

  // Opcode classification, shared by the decode registers, next-state and output logic.
  always_comb begin
    w_is_legal    = 1'b1;
    w_is_itype    = 1'b0;
    w_is_jtype    = 1'b0;
    w_is_mem      = 1'b0;
    w_writes_reg  = 1'b0;
    w_alu_op      = 3'd0;
    w_alu_src_imm = 1'b0;
    case (w_opcode)
      OP_NOP, OP_HALT: ;
      OP_ADD:  w_writes_reg = 1'b1;
      OP_SUB:  begin w_writes_reg = 1'b1; w_alu_op = 3'd1; end
      OP_AND:  begin w_writes_reg = 1'b1; w_alu_op = 3'd2; end
      OP_OR:   begin w_writes_reg = 1'b1; w_alu_op = 3'd3; end
      OP_ADDI: begin w_writes_reg = 1'b1; w_is_itype = 1'b1; w_alu_src_imm = 1'b1; end
      OP_LD:   begin w_writes_reg = 1'b1; w_is_itype = 1'b1; w_alu_src_imm = 1'b1; w_is_mem = 1'b1; end
      OP_ST:   begin w_is_itype = 1'b1; w_alu_src_imm = 1'b1; w_is_mem = 1'b1; end
      OP_JMP:  w_is_jtype = 1'b1;
      OP_BEQ:  begin w_is_itype = 1'b1; w_alu_op = 3'd1; end
      default: w_is_legal = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_FETCH;
      r_run     <= 1'b0;
      r_ir      <= '0;
      r_taken   <= 1'b0;
      r_imm_raw <= '0;
      r_imm_sel <= SEL_NONE;
      r_rd      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
    end else begin
      r_state <= w_state_next;
      r_run   <= 1'b1;
      if (r_state == S_FETCH && r_run && i_imem_ack) begin
        r_ir <= i_instr;
      end
      if (r_state == S_DECODE) begin
        r_taken <= 1'b0;
        r_rd    <= r_ir[RD_HI -: REG_ADDR_WIDTH];
        r_rs1   <= r_ir[RS1_HI -: REG_ADDR_WIDTH];
        r_rs2   <= r_ir[RS2_HI -: REG_ADDR_WIDTH];
        if (w_is_itype) begin
          r_imm_sel <= SEL_I;
          r_imm_raw <= {{(IMM_MAX_WIDTH-8){1'b0}}, r_ir[7:0]};
        end else if (w_is_jtype) begin
          r_imm_sel <= SEL_J;
          r_imm_raw <= r_ir[IMM_MAX_WIDTH-1:0];
        end else begin
          r_imm_sel <= SEL_NONE;
          r_imm_raw <= '0;
        end
      end
      if (r_state == S_EXEC) begin
        r_taken <= (w_opcode == OP_BEQ) && i_alu_zero;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH:  if (r_run && i_imem_ack) w_state_next = S_DECODE;
      S_DECODE:
`ifdef CTRL_ILLEGAL_TRAP_EN
        w_state_next = w_is_legal ? S_EXEC : S_HALTED;
`else
        w_state_next = S_EXEC;
`endif
      S_EXEC:   w_state_next = w_is_mem ? S_MEM : S_WB;
      S_MEM:    if (i_dmem_ack) w_state_next = S_WB;
      S_WB:     w_state_next = (w_opcode == OP_HALT) ? S_HALTED : S_FETCH;
      S_HALTED: w_state_next = S_HALTED;
      default:  w_state_next = S_FETCH;
    endcase
  end

  // r_run keeps the fetch request low during the first cycle out of reset.
  // ALU controls stay valid from EXEC through WB so an LD/ST address holds during MEM.
  always_comb begin
    o_imem_req    = 1'b0;
    o_dmem_req    = 1'b0;
    o_dmem_we     = 1'b0;
    o_alu_op      = 3'd0;
    o_alu_src_imm = 1'b0;
    o_reg_we      = 1'b0;
    o_wb_sel      = 1'b0;
    o_pc_we       = 1'b0;
    o_pc_sel      = 2'b00;
    o_halted      = 1'b0;
    o_illegal     = 1'b0;
    case (r_state)
      S_FETCH:  o_imem_req = r_run;
      S_DECODE: o_illegal  = ~w_is_legal;
      S_EXEC: begin
        o_alu_op      = w_alu_op;
        o_alu_src_imm = w_alu_src_imm;
      end
      S_MEM: begin
        o_alu_op      = w_alu_op;
        o_alu_src_imm = w_alu_src_imm;
        o_dmem_req    = 1'b1;
        o_dmem_we     = (w_opcode == OP_ST);
      end
      S_WB: begin
        o_alu_op      = w_alu_op;
        o_alu_src_imm = w_alu_src_imm;
        o_reg_we      = w_writes_reg;
        o_wb_sel      = (w_opcode == OP_LD);
        o_pc_we       = 1'b1;
        if (w_opcode == OP_JMP)                o_pc_sel = 2'b01;
        else if (w_opcode == OP_BEQ && r_taken) o_pc_sel = 2'b10;
      end
      S_HALTED: o_halted = 1'b1;
      default: ;
    endcase
  end

  assign o_imm_raw = r_imm_raw;
  assign o_imm_sel = r_imm_sel;
  assign o_rd      = r_rd;
  assign o_rs1     = r_rs1;
  assign o_rs2     = r_rs2;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: writeback expectations are queued at fetch and popped at o_pc_we.
module tb_ctrl_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [35:0] i_instr = '0;
  logic        i_imem_ack = 1'b0;
  logic        i_dmem_ack = 1'b0;
  logic        i_alu_zero = 1'b0;
  logic        o_imem_req, o_dmem_req, o_dmem_we, o_alu_src_imm;
  logic [13:0] o_imm_raw;
  logic [1:0]  o_imm_sel, o_pc_sel;
  logic [2:0]  o_alu_op;
  logic [3:0]  o_rd, o_rs1, o_rs2;
  logic        o_reg_we, o_wb_sel, o_pc_we, o_halted, o_illegal;

  ctrl_sequencer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_instr(i_instr), .i_imem_ack(i_imem_ack),
    .o_imem_req(o_imem_req), .i_dmem_ack(i_dmem_ack), .o_dmem_req(o_dmem_req),
    .o_dmem_we(o_dmem_we), .i_alu_zero(i_alu_zero), .o_imm_raw(o_imm_raw),
    .o_imm_sel(o_imm_sel), .o_alu_op(o_alu_op), .o_alu_src_imm(o_alu_src_imm),
    .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_reg_we(o_reg_we), .o_wb_sel(o_wb_sel),
    .o_pc_we(o_pc_we), .o_pc_sel(o_pc_sel), .o_halted(o_halted), .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  wire [41:0] all_outs = {o_imem_req, o_dmem_req, o_dmem_we, o_imm_raw, o_imm_sel, o_alu_op,
                          o_alu_src_imm, o_rd, o_rs1, o_rs2, o_reg_we, o_wb_sel, o_pc_we,
                          o_pc_sel, o_halted, o_illegal};

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] pc_sel;
    logic       reg_we;
    logic       wb_sel;
    logic [3:0] rd;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Writeback monitor: every PC update must match the oldest queued expectation.
  always @(negedge i_clk) begin
    if (i_rst_n && o_pc_we) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected got pc_we=1 want no writeback");
      end else begin
        mon_e = sb.pop_front();
        $display("wb %s pc_sel=%b reg_we=%b wb_sel=%b rd=%0d", mon_e.nm, o_pc_sel, o_reg_we, o_wb_sel, o_rd);
        if ({o_pc_sel, o_reg_we, o_wb_sel, o_rd} !== {mon_e.pc_sel, mon_e.reg_we, mon_e.wb_sel, mon_e.rd}) begin
          bad++;
          $display("FAIL wb_%s got pc_sel=%b reg_we=%b wb_sel=%b rd=%0d want pc_sel=%b reg_we=%b wb_sel=%b rd=%0d",
                   mon_e.nm, o_pc_sel, o_reg_we, o_wb_sel, o_rd,
                   mon_e.pc_sel, mon_e.reg_we, mon_e.wb_sel, mon_e.rd);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want test completion");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    i_rst_n = 1'b0; i_imem_ack = 1'b0; i_dmem_ack = 1'b0; i_alu_zero = 1'b0;
    repeat (2) @(negedge i_clk);
    sb.delete();
    i_rst_n = 1'b1;
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (!o_imem_req && n < 10) begin @(negedge i_clk); n++; end
    total++;
    if (o_imem_req !== 1'b1) begin
      bad++; $display("FAIL %s_fetch_req got=%b want=1", nm, o_imem_req);
    end
  endtask

  // Runs one instruction from FETCH to its WB cycle; returns at the WB negedge.
  task automatic exec_instr(input string nm, input logic [35:0] instr, input int imem_wait,
                            input int mem_cycles, input logic zero, input logic e_ill,
                            input logic [2:0] e_op, input logic e_src, input logic [1:0] e_sel,
                            input logic [13:0] e_raw, input logic [1:0] e_pc_sel,
                            input logic e_we, input logic e_wb, input logic e_dwe);
    exp_t e;
    e.pc_sel = e_pc_sel; e.reg_we = e_we; e.wb_sel = e_wb; e.rd = instr[31:28]; e.nm = nm;
    i_alu_zero = zero;
    wait_req(nm);
    for (int k = 0; k < imem_wait; k++) begin
      @(negedge i_clk);
      total++;
      if (o_imem_req !== 1'b1) begin bad++; $display("FAIL %s_req_hold got=%b want=1", nm, o_imem_req); end
    end
    i_instr = instr; i_imem_ack = 1'b1;
    sb.push_back(e);
    @(negedge i_clk);                                   // DECODE
    i_instr = {4'hE, $urandom()};                       // stray ack outside a request
    i_dmem_ack = (mem_cycles == 0);
    total++;
    if ({o_illegal, o_imem_req} !== {e_ill, 1'b0}) begin
      bad++; $display("FAIL %s_decode got illegal=%b req=%b want illegal=%b req=0", nm, o_illegal, o_imem_req, e_ill);
    end
    @(negedge i_clk);                                   // EXEC
    i_imem_ack = 1'b0;
    total++;
    if ({o_alu_op, o_alu_src_imm, o_imm_sel, o_imm_raw} !== {e_op, e_src, e_sel, e_raw}) begin
      bad++; $display("FAIL %s_exec got op=%0d src=%b sel=%b raw=%h want op=%0d src=%b sel=%b raw=%h",
                      nm, o_alu_op, o_alu_src_imm, o_imm_sel, o_imm_raw, e_op, e_src, e_sel, e_raw);
    end
    total++;
    if ({o_rd, o_rs1, o_rs2, o_pc_we, o_reg_we} !== {instr[31:28], instr[27:24], instr[23:20], 2'b00}) begin
      bad++; $display("FAIL %s_regs got rd=%0d rs1=%0d rs2=%0d pc_we=%b reg_we=%b want rd=%0d rs1=%0d rs2=%0d pc_we=0 reg_we=0",
                      nm, o_rd, o_rs1, o_rs2, o_pc_we, o_reg_we, instr[31:28], instr[27:24], instr[23:20]);
    end
    for (int k = 0; k < mem_cycles; k++) begin
      @(negedge i_clk);                                 // MEM
      total++;
      if ({o_dmem_req, o_dmem_we, o_pc_we} !== {1'b1, e_dwe, 1'b0}) begin
        bad++; $display("FAIL %s_mem%0d got req=%b we=%b pc_we=%b want req=1 we=%b pc_we=0",
                        nm, k, o_dmem_req, o_dmem_we, o_pc_we, e_dwe);
      end
      if (k == mem_cycles - 1) i_dmem_ack = 1'b1;
    end
    @(negedge i_clk);                                   // WB
    i_dmem_ack = 1'b0;
    total++;
    if ({o_pc_we, o_dmem_req} !== 2'b10) begin
      bad++; $display("FAIL %s_wb_latency got pc_we=%b dmem_req=%b want pc_we=1 dmem_req=0", nm, o_pc_we, o_dmem_req);
    end
  endtask

  task automatic test_reset();
    i_imem_ack = 1'b1; i_instr = 36'h131200000;
    @(negedge i_clk);
    total++;
    if (all_outs !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", all_outs); end
    i_imem_ack = 1'b0;
    i_rst_n = 1'b1;
    #1;
    total++;
    if (o_imem_req !== 1'b0) begin bad++; $display("FAIL reset_release_req got=%b want=0", o_imem_req); end
    @(negedge i_clk);
    total++;
    if (o_imem_req !== 1'b1) begin bad++; $display("FAIL reset_first_req got=%b want=1", o_imem_req); end
    $display("reset done");
  endtask

  task automatic test_alu_ops();
    exec_instr("add", 36'h131200000, 0, 0, 1'b0, 1'b0, 3'd0, 1'b0, 2'b00, 14'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    exec_instr("sub", 36'h246700000, 0, 0, 1'b0, 1'b0, 3'd1, 1'b0, 2'b00, 14'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    exec_instr("and", 36'h389A00000, 0, 0, 1'b0, 1'b0, 3'd2, 1'b0, 2'b00, 14'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    exec_instr("or",  36'h4BCD00000, 0, 0, 1'b0, 1'b0, 3'd3, 1'b0, 2'b00, 14'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    exec_instr("nop", 36'h0A1200000, 0, 0, 1'b0, 1'b0, 3'd0, 1'b0, 2'b00, 14'h0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_addi();
    exec_instr("addi", 36'h551003FA5, 0, 0, 1'b0, 1'b0, 3'd0, 1'b1, 2'b01, 14'h00A5, 2'b00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_jmp();
    exec_instr("jmp", 36'h8200FFFFF, 0, 0, 1'b0, 1'b0, 3'd0, 1'b0, 2'b10, 14'h3FFF, 2'b01, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_ld_st();
    exec_instr("ld", 36'h671000010, 0, 3, 1'b0, 1'b0, 3'd0, 1'b1, 2'b01, 14'h0010, 2'b00, 1'b1, 1'b1, 1'b0);
    exec_instr("st", 36'h702900020, 0, 1, 1'b0, 1'b0, 3'd0, 1'b1, 2'b01, 14'h0020, 2'b00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_beq();
    exec_instr("beq_t", 36'h901200004, 0, 0, 1'b1, 1'b0, 3'd1, 1'b0, 2'b01, 14'h0004, 2'b10, 1'b0, 1'b0, 1'b0);
    exec_instr("beq_n", 36'h934500081, 0, 0, 1'b0, 1'b0, 3'd1, 1'b0, 2'b01, 14'h0081, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    exec_instr("add_wait", 36'h1EDC00000, 2, 0, 1'b0, 1'b0, 3'd0, 1'b0, 2'b00, 14'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    exec_instr("or_b2b",   36'h412300000, 0, 0, 1'b0, 1'b0, 3'd3, 1'b0, 2'b00, 14'h0, 2'b00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_illegal();
`ifdef CTRL_ILLEGAL_TRAP_EN
    wait_req("ill_trap");
    i_instr = 36'hC123000FF; i_imem_ack = 1'b1;
    @(negedge i_clk);
    i_imem_ack = 1'b0;
    total++;
    if (o_illegal !== 1'b1) begin bad++; $display("FAIL ill_trap_pulse got=%b want=1", o_illegal); end
    @(negedge i_clk);
    total++;
    if ({o_illegal, o_halted, o_pc_we, o_reg_we} !== 4'b0100) begin
      bad++; $display("FAIL ill_trap_halt got illegal=%b halted=%b pc_we=%b reg_we=%b want 0 1 0 0",
                      o_illegal, o_halted, o_pc_we, o_reg_we);
    end
    $display("illegal trapped halted=%b", o_halted);
    apply_reset();
`else
    exec_instr("ill_nop", 36'hC123000FF, 0, 0, 1'b0, 1'b1, 3'd0, 1'b0, 2'b00, 14'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
    total++;
    if ({o_imem_req, o_halted, o_illegal} !== 3'b100) begin
      bad++; $display("FAIL ill_next_fetch got req=%b halted=%b illegal=%b want 1 0 0", o_imem_req, o_halted, o_illegal);
    end
`endif
  endtask

  task automatic test_halt();
    exec_instr("halt", 36'hF56700000, 0, 0, 1'b0, 1'b0, 3'd0, 1'b0, 2'b00, 14'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    i_imem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      total++;
      if ({o_halted, o_imem_req, o_pc_we} !== 3'b100) begin
        bad++; $display("FAIL halt_hold%0d got halted=%b req=%b pc_we=%b want 1 0 0", k, o_halted, o_imem_req, o_pc_we);
      end
    end
    $display("halted=%b", o_halted);
    apply_reset();
    @(negedge i_clk);
    total++;
    if ({o_halted, o_imem_req} !== 2'b01) begin
      bad++; $display("FAIL halt_reset got halted=%b req=%b want 0 1", o_halted, o_imem_req);
    end
  endtask

  task automatic test_reset_mid_mem();
    wait_req("rst_mem");
    i_instr = 36'h6A3000055; i_imem_ack = 1'b1;
    repeat (3) @(negedge i_clk);                        // DECODE, EXEC, MEM
    i_imem_ack = 1'b0;
    total++;
    if (o_dmem_req !== 1'b1) begin bad++; $display("FAIL rst_mem_req got=%b want=1", o_dmem_req); end
    i_dmem_ack = 1'b1;
    #2 i_rst_n = 1'b0;
    #1;
    total++;
    if (all_outs !== '0) begin bad++; $display("FAIL rst_mem_outputs got=%h want=0", all_outs); end
    $display("reset mid-mem dmem_req=%b", o_dmem_req);
    apply_reset();
  endtask

  task automatic test_reset_mid_fetch();
    exec_instr("sub_pre", 36'h2FED00000, 0, 0, 1'b0, 1'b0, 3'd1, 1'b0, 2'b00, 14'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    wait_req("rst_fetch");
    #2 i_rst_n = 1'b0;
    #1;
    total++;
    if (all_outs !== '0) begin bad++; $display("FAIL rst_fetch_outputs got=%h want=0", all_outs); end
    $display("reset mid-fetch imem_req=%b rd=%0d", o_imem_req, o_rd);
    apply_reset();
    exec_instr("add_post", 36'h131200000, 0, 0, 1'b0, 1'b0, 3'd0, 1'b0, 2'b00, 14'h0, 2'b00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_addi();
    test_jmp();
    test_ld_st();
    test_beq();
    test_back_to_back();
    test_illegal();
    test_halt();
    test_reset_mid_mem();
    test_reset_mid_fetch();
    @(negedge i_clk);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_drain got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Multi-cycle control unit for the 36-bit core.
- Fetches an instruction over a req/ack handshake and latches it into an internal instruction register (IR).
- Decodes the IR and drives the immediate extender's raw field and type select, the ALU op, register-file addresses and enables, the data-memory handshake and the PC update.
- Sits between instruction memory and the datapath (register file, imm_extender, ALU, PC).

Parameters:
- DATA_WIDTH, 36, instruction/data word width.
- IMM_MAX_WIDTH, 14, width of o_imm_raw (widest immediate field).
- SELECT_WIDTH, 2, width of o_imm_sel.
- REG_ADDR_WIDTH, 4, register address width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_instr  in  DATA_WIDTH  instruction-memory read data; valid when i_imem_ack=1.
- i_imem_ack  in  1  instruction-memory ack.
- o_imem_req  out  1  instruction fetch request.
- i_dmem_ack  in  1  data-memory ack.
- o_dmem_req  out  1  data-memory request.
- o_dmem_we  out  1  data-memory write (ST).
- i_alu_zero  in  1  ALU zero flag.
- o_imm_raw  out  IMM_MAX_WIDTH  raw immediate to the extender.
- o_imm_sel  out  SELECT_WIDTH  immediate type: 00 none, 01 I-type (8-bit), 10 J-type (14-bit).
- o_alu_op  out  3  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR.
- o_alu_src_imm  out  1  ALU operand B select: 1 = extended immediate, 0 = rs2.
- o_rd, o_rs1, o_rs2  out  REG_ADDR_WIDTH  register addresses.
- o_reg_we  out  1  register-file write enable.
- o_wb_sel  out  1  write-back source: 0 ALU result, 1 data-memory read data.
- o_pc_we  out  1  PC update strobe.
- o_pc_sel  out  2  next PC: 00 PC+1, 01 jump target, 10 branch target.
- o_halted  out  1  core halted.
- o_illegal  out  1  one-cycle pulse on an illegal opcode.

Behaviour:
- Instruction format:
  - opcode = IR[35:32]
  - rd = IR[31:28], rs1 = IR[27:24], rs2 = IR[23:20]
  - imm8 = IR[7:0], imm14 = IR[13:0]
- Opcodes:
  - 0 NOP (R)
  - 1 ADD, 2 SUB, 3 AND, 4 OR (R)
  - 5 ADDI (I)
  - 6 LD, 7 ST (I; address = rs1 + imm)
  - 8 JMP (J)
  - 9 BEQ (I; compares rs1, rs2 with SUB; taken when i_alu_zero=1)
  - F HALT
  - all others illegal.
- Reset (asynchronous, i_rst_n=0):
  - State goes to FETCH and IR clears to 0.
  - All outputs go to 0.
  - o_imem_req asserts on the first clock after reset is released.
- FETCH:
  - o_imem_req=1 and held until i_imem_ack.
  - On ack, IR<=i_instr and next state is DECODE.
- DECODE (1 cycle):
  - Registered outputs o_imm_raw, o_imm_sel, o_rd/rs1/rs2 update from IR and stay stable until the next DECODE.
  - R-type: imm_sel=00, imm_raw=0.
  - I-type: imm_sel=01, imm_raw={6'b0, imm8}.
  - J-type: imm_sel=10, imm_raw=imm14.
  - Illegal opcode: o_illegal pulses, then the instruction is handled as NOP.
- EXEC (1 cycle):
  - Drives o_alu_op and o_alu_src_imm.
  - BEQ samples i_alu_zero into a taken flag.
  - LD/ST go to MEM; all other opcodes go to WB.
- MEM:
  - o_dmem_req=1 (o_dmem_we=1 for ST), held until i_dmem_ack, then WB.
- WB (1 cycle):
  - o_reg_we=1 for ADD/SUB/AND/OR/ADDI/LD; o_wb_sel=1 for LD.
  - o_pc_we=1 for every instruction. o_pc_sel = 01 for JMP, 10 for BEQ taken, 00 otherwise.
  - Next state FETCH; HALT goes to HALTED instead.
- HALTED:
  - o_halted=1, no requests issued; left only by reset.
- Latency with zero-wait acks: 4 cycles FETCH→WB for non-memory instructions, 5 for LD/ST.
- Boundary conditions:
  - An ack outside its request is ignored.
  - Reset mid-MEM drops o_dmem_req immediately, whatever the ack state.
  - o_reg_we is never asserted for NOP or illegal instructions.

Optional Feature:
- Macro CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE goes straight to HALTED (o_illegal pulses, o_halted=1, no PC update).
- Undefined: the illegal opcode executes as NOP and the PC advances by 1.

Test Plan:
- Reset, then i_instr=0x1_3_1_2_00000 (ADD r3=r1+r2) with immediate ack → imm_sel=00, alu_op=0, reg_we pulse in cycle 4 with rd=3, pc_sel=00.
- ADDI with imm8=0xA5 → o_imm_raw=0x00A5, imm_sel=01, alu_src_imm=1, rd written.
- JMP with imm14=0x3FFF → imm_sel=10, o_imm_raw=0x3FFF, pc_we with pc_sel=01, reg_we stays 0.
- LD with i_dmem_ack delayed 3 cycles → dmem_req held 3 cycles, wb_sel=1, reg_we asserted the cycle after ack.
- BEQ with i_alu_zero=1 → pc_sel=10; BEQ with i_alu_zero=0 → pc_sel=00.
- Opcode 0xC → o_illegal pulse; without the macro the next fetch follows, with CTRL_ILLEGAL_TRAP_EN o_halted=1. Assert i_rst_n=0 mid-fetch → all outputs 0 asynchronously.
